bist_misr_ctrl: RTL and testbench
=================================

// Module: bist_misr_ctrl
// PURPOSE
//  Parametrised multiple-input signature register with on-board session control.
//  - Compacts WIDTH-bit CUT responses over a programmed number of vectors.
//  - Compares the final signature against a golden value and reports pass/fail.
//  - Sits at the output of the BIST datapath. Replaces the fixed 8-bit free-running MISR.
// PARAMETERS
//  WIDTH   8        signature / response width, >= 2
//  POLY    8'hB8    feedback tap mask; bit i set => q[i] feeds the XOR parity
//  SEED    0        signature value loaded at reset and at every start
//  CYCLES  255      number of enabled compaction cycles per session, >= 1
//  CNT_W   $clog2(CYCLES+1)  width of the vector counter (derived)
// PORTS
//  clk     in   1      single clock; all state changes on its rising edge
//  rst     in   1      asynchronous reset, active-low (0 = reset)
//  start   in   1      1-cycle pulse: load SEED, clear counter, begin session
//  en      in   1      response valid; compaction occurs only when en=1 in RUN
//  z       in   WIDTH  CUT response vector
//  golden  in   WIDTH  expected signature, sampled when the session ends
//  qout    out  WIDTH  current signature register
//  busy    out  1      1 while in RUN
//  done    out  1      1 while in DONE (level, not pulse)
//  pass    out  1      valid when done=1: 1 iff the final qout equals golden
// BEHAVIOUR
//  - Reset (rst=0, async):
//    - state=IDLE, qout=SEED, cnt=0, busy=0, done=0, pass=0.
//    - Takes effect mid-session too; the session is abandoned and no done is raised.
//  - FSM states:
//    - IDLE: wait for start.
//    - RUN: compact responses.
//    - DONE: hold the result.
//  - Transitions:
//    - IDLE -start-> RUN
//    - RUN -(en & cnt==CYCLES-1)-> DONE
//    - DONE -start-> RUN
//  - Loading and restart:
//    - Every start: qout<=SEED, cnt<=0. This applies in any state, including a restart mid-RUN.
//    - A start that coincides with en is a load only; that z is not compacted.
//  - Compaction, RUN and en=1 and no start:
//    - fb = ^(qout & POLY)
//    - qout <= {qout[WIDTH-2:0], fb} ^ z
//    - cnt <= cnt+1
//    - The response on the last cycle (cnt==CYCLES-1) is compacted. The FSM enters DONE
//      on the same edge.
//  - en=0 in RUN: qout and cnt hold. No timeout.
//  - Result outputs:
//    - pass is registered on the RUN->DONE edge: pass <= (next qout == golden).
//    - done and pass appear 1 cycle after the final enabled response.
//  - IDLE/DONE: z and en are ignored, and qout holds.
//    - In DONE, qout, pass and done stay stable until start or reset.
//  - busy=(state==RUN) and done=(state==DONE), both registered. They are never both 1.
//  - Arithmetic: all XOR/shift is modulo WIDTH bits. The counter never exceeds CYCLES-1.
// STRUCTURE
//  - bist_pkg holds:
//    - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
//    - default tap constants per width (8'hB8, 16'hB400, 32'h80200003)
//  - Sub-module misr_core(WIDTH,POLY,SEED) holds the pure datapath register:
//    - inputs: load, shift, z
//    - output: q
//  - The top holds the FSM, the counter and the compare.
// TESTING  (WIDTH=8, POLY=8'hB8, SEED=8'h00, CYCLES=4)
//  1. Hold rst=0 with z=8'hFF and en=1 toggling
//     -> qout=00, busy=0, done=0, pass=0 throughout.
//  2. start, then 4 cycles en=1 with z=8'hAA
//     -> qout sequence AA, FF, 54, 03. done=1 one cycle after the 4th edge.
//     -> golden=03 gives pass=1.
//  3. Same as 2 with golden=8'h04 -> final qout=03, done=1, pass=0.
//  4. Same as 2 with en=0 inserted for 3 cycles after the 2nd vector
//     -> qout holds FF during the gap, final 03, pass=1.
//  5. start, 2 vectors (qout=FF), then start again, then 4 vectors of AA
//     -> qout reloads 00, final 03, pass=1.
//  6. Assert rst=0 asynchronously mid-RUN after 3 vectors (qout=54)
//     -> qout=00 and state=IDLE immediately, with no clock edge.
//     -> done stays 0 until a new start completes.

Source files
------------

// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bist_pkg
//  Description : Shared constants for the BIST signature compactor:
//                FSM state encoding and default MISR feedback taps per width.
//  Revision    : 1.0  - initial release
// ============================================================================
package bist_pkg;

    // Session controller state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Default maximal-length feedback tap masks
    localparam logic [7:0]  C_POLY_W8  = 8'hB8;
    localparam logic [15:0] C_POLY_W16 = 16'hB400;
    localparam logic [31:0] C_POLY_W32 = 32'h8020_0003;

    // Pick a default tap mask for a given width; widths without a listed
    // entry fall back to the 8-bit mask in the low byte.
    function automatic logic [31:0] default_poly(input int width);
        logic [31:0] poly;
        case (width)
            16:      poly = {16'h0000, C_POLY_W16};
            32:      poly = C_POLY_W32;
            default: poly = {24'h00_0000, C_POLY_W8};
        endcase
        return poly;
    endfunction

endpackage
`default_nettype wire

// File: rtl/misr_core.sv
`default_nettype none
// ============================================================================
//  Module      : misr_core
//  Description : Pure MISR datapath register. Loads SEED on load, otherwise
//                compacts one response vector per shift.
//  Revision    : 1.0  - initial release
// ============================================================================
module misr_core #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;
    logic             w_fb;
    logic [WIDTH-1:0] w_q_next;

    // Parity of the tapped bits becomes the new LSB; the response is folded in
    assign w_fb     = ^(r_q & POLY);
    assign w_q_next = {r_q[WIDTH-2:0], w_fb} ^ z;

    // Signature register: load takes priority over compaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= SEED;
        end else if (load) begin
            r_q <= SEED;
        end else if (shift) begin
            r_q <= w_q_next;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/bist_misr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bist_misr_ctrl
//  Description : Multiple-input signature register with session control.
//                Compacts CYCLES enabled responses, then compares the final
//                signature against golden and holds pass/done until restart.
//  Revision    : 1.0  - initial release
// ============================================================================
module bist_misr_ctrl
    import bist_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] POLY   = WIDTH'(default_poly(WIDTH)),
    parameter logic [WIDTH-1:0] SEED   = '0,
    parameter int               CYCLES = 255,
    parameter int               CNT_W  = $clog2(CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic [WIDTH-1:0] z,
    input  logic [WIDTH-1:0] golden,
    output logic [WIDTH-1:0] qout,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [CNT_W-1:0] r_cnt;

    logic             w_run;
    logic             w_shift;
    logic             w_last;
    logic [WIDTH-1:0] w_q;
    logic             w_fb;
    logic [WIDTH-1:0] w_q_next;

    // A start is always a pure load, so it suppresses compaction of that z
    assign w_run   = (r_state == ST_RUN);
    assign w_shift = w_run & en & ~start;
    assign w_last  = w_shift & (r_cnt == C_CNT_LAST);

    misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr_core (
        .clk   (clk),
        .rst   (rst),
        .load  (start),
        .shift (w_shift),
        .z     (z),
        .q     (w_q)
    );

    // Signature the core will hold after this edge; the verdict is taken on
    // the value being written, not the one currently in the register.
    assign w_fb     = ^(w_q & POLY);
    assign w_q_next = {w_q[WIDTH-2:0], w_fb} ^ z;

    // Next-state decode; start restarts from any state, illegal codes recover
    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = ST_RUN;
        end else begin
            case (r_state)
                ST_IDLE: w_state_next = ST_IDLE;
                ST_RUN:  w_state_next = w_last ? ST_DONE : ST_RUN;
                ST_DONE: w_state_next = ST_DONE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // State register with registered busy/done flags decoded from next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_RUN);
            r_done  <= (w_state_next == ST_DONE);
        end
    end

    // Vector counter: cleared on start, wraps to zero as the session closes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else if (w_shift) begin
            r_cnt <= r_cnt + C_CNT_ONE;
        end
    end

    // Verdict: captured once on the final compaction, cleared by a new start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pass <= 1'b0;
        end else if (start) begin
            r_pass <= 1'b0;
        end else if (w_last) begin
            r_pass <= (w_q_next == golden);
        end
    end

    assign qout = w_q;
    assign busy = r_busy;
    assign done = r_done;
    assign pass = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_bist_misr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bist_misr_ctrl
//  Description : Scoreboard bench for bist_misr_ctrl (WIDTH=8, POLY=B8,
//                SEED=00, CYCLES=4) with hand-computed signatures.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_bist_misr_ctrl;

    typedef struct packed {
        logic [7:0] q;
        logic       p;
    } res_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       en;
    logic [7:0] z;
    logic [7:0] golden;
    logic [7:0] qout;
    logic       busy;
    logic       done;
    logic       pass;

    int         checks;
    int         errors;
    logic [7:0] q_exp[$];
    res_t       r_exp[$];
    logic       acc;
    logic       done_prev;

    bist_misr_ctrl #(
        .WIDTH  (8),
        .POLY   (8'hB8),
        .SEED   (8'h00),
        .CYCLES (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .en     (en),
        .z      (z),
        .golden (golden),
        .qout   (qout),
        .busy   (busy),
        .done   (done),
        .pass   (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: note whether a response was accepted on this edge
    always @(posedge clk) begin
        acc = busy && en && !start;
    end

    // Monitor: pop and compare per accepted vector and per completed session
    always @(negedge clk) begin
        logic [7:0] e;
        res_t       r;
        if (acc) begin
            if (q_exp.size() == 0) begin
                chk("unexpected_vector", 32'(qout), 32'hFFFF_FFFF);
            end else begin
                e = q_exp.pop_front();
                chk("qout_vec", 32'(qout), 32'(e));
            end
        end
        if (done && !done_prev) begin
            if (r_exp.size() == 0) begin
                chk("unexpected_done", 32'(qout), 32'hFFFF_FFFF);
            end else begin
                r = r_exp.pop_front();
                chk("final_qout", 32'(qout), 32'(r.q));
                chk("final_pass", 32'(pass), 32'(r.p));
                chk("final_busy", 32'(busy), 32'h0);
            end
        end
        if (busy && done) begin
            chk("busy_done_excl", 32'({busy, done}), 32'h0);
        end
        done_prev = done;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic en_v);
        start = 1'b1;
        en    = en_v;
        z     = 8'hAA;
        tick();
        start = 1'b0;
        en    = 1'b0;
    endtask

    task automatic vec(input logic [7:0] zv, input logic [7:0] expq);
        en = 1'b1;
        z  = zv;
        q_exp.push_back(expq);
        tick();
        en = 1'b0;
    endtask

    task automatic wait_done;
        int n;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'h1);
    endtask

    // Standard four-vector session of AA: AA, FF, 54, 03
    task automatic session4(input logic [7:0] gold, input logic exp_pass);
        golden = gold;
        vec(8'hAA, 8'hAA);
        vec(8'hAA, 8'hFF);
        vec(8'hAA, 8'h54);
        r_exp.push_back('{q: 8'h03, p: exp_pass});
        vec(8'hAA, 8'h03);
        wait_done();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        acc       = 1'b0;
        done_prev = 1'b0;
        rst       = 1'b0;
        start     = 1'b0;
        en        = 1'b0;
        z         = 8'hFF;
        golden    = 8'h00;

        // 1: reset held, inputs toggling
        for (int i = 0; i < 3; i++) begin
            en = ~en;
            @(negedge clk);
            chk("rst_qout", 32'(qout), 32'h00);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_done", 32'(done), 32'h0);
            chk("rst_pass", 32'(pass), 32'h0);
        end
        en  = 1'b0;
        #2;
        rst = 1'b1;
        tick();

        // 2: basic session, matching golden
        do_start(1'b0);
        chk("start_busy", 32'(busy), 32'h1);
        chk("start_qout", 32'(qout), 32'h00);
        session4(8'h03, 1'b1);
        // DONE holds regardless of en/z
        en = 1'b1;
        z  = 8'h5A;
        for (int i = 0; i < 3; i++) tick();
        en = 1'b0;
        chk("hold_qout", 32'(qout), 32'h03);
        chk("hold_done", 32'(done), 32'h1);
        chk("hold_pass", 32'(pass), 32'h1);
        chk("hold_busy", 32'(busy), 32'h0);

        // 3: mismatching golden, start from DONE
        do_start(1'b0);
        chk("restart_done", 32'(done), 32'h0);
        chk("restart_pass", 32'(pass), 32'h0);
        session4(8'h04, 1'b0);

        // 4: three-cycle en gap after second vector
        do_start(1'b0);
        golden = 8'h03;
        vec(8'hAA, 8'hAA);
        vec(8'hAA, 8'hFF);
        z = 8'h11;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gap_qout", 32'(qout), 32'hFF);
            chk("gap_busy", 32'(busy), 32'h1);
        end
        vec(8'hAA, 8'h54);
        r_exp.push_back('{q: 8'h03, p: 1'b1});
        vec(8'hAA, 8'h03);
        wait_done();

        // 5: restart mid-RUN; the restart coincides with en and is load only
        do_start(1'b0);
        golden = 8'h03;
        vec(8'hAA, 8'hAA);
        vec(8'hAA, 8'hFF);
        do_start(1'b1);
        chk("reload_qout", 32'(qout), 32'h00);
        session4(8'h03, 1'b1);

        // 6: asynchronous reset mid-RUN
        do_start(1'b0);
        vec(8'hAA, 8'hAA);
        vec(8'hAA, 8'hFF);
        vec(8'hAA, 8'h54);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_qout", 32'(qout), 32'h00);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        #1;
        rst = 1'b1;
        en  = 1'b1;
        z   = 8'h33;
        for (int i = 0; i < 3; i++) tick();
        en = 1'b0;
        chk("idle_qout", 32'(qout), 32'h00);
        chk("idle_done", 32'(done), 32'h0);
        do_start(1'b0);
        session4(8'h03, 1'b1);

        tick();
        chk("sb_empty", 32'(q_exp.size() + r_exp.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
